// File: rtl/secp256k1_fe_alu_ctrl.sv
// ---------------------------------------------------------------------------
// secp256k1_fe_alu_ctrl
//
// Field-element register file and command sequencer wrapped around an
// external secp256k1 modular adder. Commands name registers; the block
// snapshots the operands, runs the adder for ADD/SUB/DBL and writes the
// result back into the register file. MOV copies a register without
// touching the adder.
//
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   cmd_valid/ready     command handshake (ready only while idle)
//   cmd_op              0=ADD, 1=SUB, 2=DBL, 3=MOV
//   cmd_dst/srca/srcb   destination and source register indices
//   cmd_done            one-cycle pulse once the destination is written
//   wr_en/addr/data     host register load port (data must be < p)
//   rd_addr/rd_data     host readback port, registered, 1-cycle latency
//   add_start/a/b       request to the modular adder
//   add_result/done     response from the modular adder
//   err                 sticky adder timeout flag
//
// Optional build macro:
//   SECP256K1_FE_ALU_TIMEOUT_EN  enables the adder watchdog. When it is
//   undefined there is no watchdog, err is tied low and the block waits
//   for add_done indefinitely.
// ---------------------------------------------------------------------------
module secp256k1_fe_alu_ctrl #(
  parameter int NREGS          = 8,
  parameter int AW             = 3,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [AW-1:0] cmd_dst,
  input  logic [AW-1:0] cmd_srca,
  input  logic [AW-1:0] cmd_srcb,
  output logic          cmd_done,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [255:0]  wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [255:0]  rd_data,
  output logic          add_start,
  output logic [255:0]  add_a,
  output logic [255:0]  add_b,
  input  logic [255:0]  add_result,
  input  logic          add_done,
  output logic          err
);

  // secp256k1 field prime p = 2^256 - 2^32 - 977
  localparam logic [255:0] P =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_DBL = 2'd2,
    OP_MOV = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_WB    = 2'd3
  } state_e;

  state_e        r_state;
  logic [255:0]  r_regs [NREGS];
  logic [AW-1:0] r_dst;
  logic [255:0]  r_opA;
  logic [255:0]  r_opB;
  logic [255:0]  r_result;
  logic [255:0]  r_rdData;
  logic          r_addStart;
  logic          r_cmdDone;

  logic [255:0]  w_srcA;
  logic [255:0]  w_srcB;
  logic [255:0]  w_negB;
  logic [255:0]  w_opB;
  logic          w_accept;
  logic          w_wbHit;

`ifdef SECP256K1_FE_ALU_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_timer;
  logic          r_err;
  assign err = r_err;
`else
  logic [31:0]   w_unusedTimeout;
  assign w_unusedTimeout = TIMEOUT_CYCLES;
  assign err = 1'b0;
`endif

  assign cmd_ready = (r_state == S_IDLE);
  assign w_accept  = cmd_valid && cmd_ready;

  assign w_srcA = r_regs[cmd_srca];
  assign w_srcB = r_regs[cmd_srcb];

  // Subtraction reuses the adder by adding the additive inverse. Zero is
  // its own inverse; any other reduced value b gives p - b, which is
  // strictly less than p, so no borrow or extra reduction is needed.
  assign w_negB = (w_srcB == '0) ? '0 : (P - w_srcB);

  // Operand B selection per opcode; MOV never reaches the adder.
  always_comb begin
    w_opB = w_srcB;
    unique case (op_e'(cmd_op))
      OP_ADD:  w_opB = w_srcB;
      OP_SUB:  w_opB = w_negB;
      OP_DBL:  w_opB = w_srcA;
      OP_MOV:  w_opB = w_srcB;
      default: w_opB = w_srcB;
    endcase
  end

  // A host write that lands on the register being written back loses.
  assign w_wbHit = (r_state == S_WB) && (wr_addr == r_dst);

  // Sequencer, register file and registered outputs share one process so
  // the host-write/writeback priority lives in a single place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_dst      <= '0;
      r_opA      <= '0;
      r_opB      <= '0;
      r_result   <= '0;
      r_rdData   <= '0;
      r_addStart <= 1'b0;
      r_cmdDone  <= 1'b0;
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
`ifdef SECP256K1_FE_ALU_TIMEOUT_EN
      r_timer    <= '0;
      r_err      <= 1'b0;
`endif
    end else begin
      r_addStart <= 1'b0;
      r_cmdDone  <= 1'b0;
      r_rdData   <= r_regs[rd_addr];

      if (wr_en && !w_wbHit) begin
        r_regs[wr_addr] <= wr_data;
      end

      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_dst <= cmd_dst;
            if (op_e'(cmd_op) == OP_MOV) begin
              r_result <= w_srcA;
              r_state  <= S_WB;
            end else begin
              r_opA      <= w_srcA;
              r_opB      <= w_opB;
              r_addStart <= 1'b1;
              r_state    <= S_ISSUE;
            end
          end
        end

        S_ISSUE: begin
`ifdef SECP256K1_FE_ALU_TIMEOUT_EN
          r_timer <= '0;
`endif
          r_state <= S_WAIT;
        end

        S_WAIT: begin
          if (add_done) begin
            r_result <= add_result;
            r_state  <= S_WB;
          end
`ifdef SECP256K1_FE_ALU_TIMEOUT_EN
          else if (r_timer == TW'(TIMEOUT_CYCLES - 1)) begin
            r_err   <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
`endif
        end

        S_WB: begin
          r_regs[r_dst] <= r_result;
          r_cmdDone     <= 1'b1;
          r_state       <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign add_start = r_addStart;
  assign add_a     = r_opA;
  assign add_b     = r_opB;
  assign cmd_done  = r_cmdDone;
  assign rd_data   = r_rdData;

endmodule

// File: tb/tb_secp256k1_fe_alu_ctrl.sv
// ---------------------------------------------------------------------------
// tb_secp256k1_fe_alu_ctrl
//
// Directed bench for the field-element command sequencer. A behavioural
// modular adder answers add_start after a programmable delay. Expected
// register contents are queued when a command is issued and compared
// against the readback port when cmd_done fires.
// ---------------------------------------------------------------------------
module tb_secp256k1_fe_alu_ctrl;

  localparam int AW = 3;
  localparam logic [255:0] P =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [AW-1:0] cmd_dst;
  logic [AW-1:0] cmd_srca;
  logic [AW-1:0] cmd_srcb;
  logic          cmd_done;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [255:0]  wr_data;
  logic [AW-1:0] rd_addr;
  logic [255:0]  rd_data;
  logic          add_start;
  logic [255:0]  add_a;
  logic [255:0]  add_b;
  logic [255:0]  add_result;
  logic          add_done;
  logic          err;

  secp256k1_fe_alu_ctrl #(
    .NREGS(8),
    .AW(AW),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op(cmd_op),
    .cmd_dst(cmd_dst),
    .cmd_srca(cmd_srca),
    .cmd_srcb(cmd_srcb),
    .cmd_done(cmd_done),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .add_start(add_start),
    .add_a(add_a),
    .add_b(add_b),
    .add_result(add_result),
    .add_done(add_done),
    .err(err)
  );

  always #5 clk = ~clk;

  int cycleCnt = 0;
  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  typedef struct {
    string         tag;
    logic [AW-1:0] addr;
    logic [255:0]  value;
  } sb_entry_t;

  sb_entry_t sbQueue[$];

  int checks = 0;
  int errors = 0;

  // Adder model state shared with the stimulus process.
  logic         modelOn = 1'b1;
  int           modelDelay = 2;
  int           countdown = -1;
  logic [255:0] savedA = '0;
  logic [255:0] savedB = '0;
  int           startCount = 0;
  logic         operandMoved = 1'b0;
  int           doneCycle = 0;
  logic         doneValid = 1'b0;
  logic         injectDone = 1'b0;
  logic [255:0] injectValue = '0;

  int acceptCycle = 0;
  int doneSeenCycle = 0;

  function automatic logic [255:0] fieldAdd(input logic [255:0] a, input logic [255:0] b);
    logic [256:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, P}) s = s - {1'b0, P};
    return s[255:0];
  endfunction

  // Behavioural adder: answers each start after modelDelay idle cycles and
  // flags any movement of the operands while the request is outstanding.
  initial begin
    add_done   = 1'b0;
    add_result = '0;
    forever begin
      @(posedge clk);
      #2;
      add_done = 1'b0;
      if (countdown >= 0 && (add_a !== savedA || add_b !== savedB)) operandMoved = 1'b1;
      if (injectDone) begin
        add_done    = 1'b1;
        add_result  = injectValue;
        injectDone  = 1'b0;
      end else if (countdown == 0) begin
        add_done   = 1'b1;
        add_result = fieldAdd(savedA, savedB);
        doneCycle  = cycleCnt;
        doneValid  = 1'b1;
        countdown  = -1;
      end else if (countdown > 0) begin
        countdown = countdown - 1;
      end
      if (add_start === 1'b1) begin
        startCount = startCount + 1;
        if (modelOn) begin
          savedA    = add_a;
          savedB    = add_b;
          countdown = modelDelay;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic hostWrite(input logic [AW-1:0] addr, input logic [255:0] data);
    wr_en   = 1'b1;
    wr_addr = addr;
    wr_data = data;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic readReg(input logic [AW-1:0] addr);
    rd_addr = addr;
    tick();
  endtask

  // Waits for the block to be idle, presents one command for one cycle and
  // queues the expected destination contents when a writeback is due.
  task automatic applyStimulus(input string tag, input logic [1:0] op, input logic [AW-1:0] dst,
                               input logic [AW-1:0] srca, input logic [AW-1:0] srcb,
                               input logic expectWb, input logic [255:0] expVal);
    sb_entry_t e;
    for (int i = 0; i < 50 && cmd_ready !== 1'b1; i++) tick();
    checkOutput({tag, "_ready"}, 256'(cmd_ready), 256'(1));
    cmd_valid   = 1'b1;
    cmd_op      = op;
    cmd_dst     = dst;
    cmd_srca    = srca;
    cmd_srcb    = srcb;
    acceptCycle = cycleCnt;
    if (expectWb) begin
      e.tag   = tag;
      e.addr  = dst;
      e.value = expVal;
      sbQueue.push_back(e);
    end
    tick();
    cmd_valid = 1'b0;
  endtask

  // Bounded wait for cmd_done, then pops the scoreboard and reads the
  // destination back; the pulse must already be gone on the next cycle.
  task automatic waitDone(input string tag);
    sb_entry_t e;
    for (int i = 0; i < 100 && cmd_done !== 1'b1; i++) tick();
    checkOutput({tag, "_done"}, 256'(cmd_done), 256'(1));
    doneSeenCycle = cycleCnt;
    checkOutput({tag, "_sb"}, 256'(sbQueue.size()), 256'(1));
    if (sbQueue.size() > 0) begin
      e = sbQueue.pop_front();
      readReg(e.addr);
      checkOutput(e.tag, rd_data, e.value);
    end else begin
      tick();
    end
    checkOutput({tag, "_pulse"}, 256'(cmd_done), 256'(0));
  endtask

  initial begin
    int opCount;
    int doneHits;

    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_dst   = '0;
    cmd_srca  = '0;
    cmd_srcb  = '0;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    rd_addr   = '0;

    // Reset state
    repeat (3) tick();
    checkOutput("rst_ready", 256'(cmd_ready), 256'(1));
    checkOutput("rst_start", 256'(add_start), 256'(0));
    checkOutput("rst_done", 256'(cmd_done), 256'(0));
    checkOutput("rst_a", add_a, '0);
    checkOutput("rst_b", add_b, '0);
    checkOutput("rst_rd", rd_data, '0);
    checkOutput("rst_err", 256'(err), 256'(0));
    rst_n = 1'b1;
    tick();

    hostWrite(3'd0, P - 256'd1);
    hostWrite(3'd1, 256'd2);
    readReg(3'd0);
    checkOutput("load_r0", rd_data, P - 256'd1);

    // ADD wraps: (p-1) + 2 = 1
    opCount      = startCount;
    operandMoved = 1'b0;
    applyStimulus("add_wrap", 2'd0, 3'd2, 3'd0, 3'd1, 1'b1, 256'd1);
    checkOutput("add_start_hi", 256'(add_start), 256'(1));
    checkOutput("add_a", add_a, P - 256'd1);
    checkOutput("add_b", add_b, 256'd2);
    checkOutput("add_busy", 256'(cmd_ready), 256'(0));
    tick();
    checkOutput("add_start_lo", 256'(add_start), 256'(0));
    waitDone("add_wrap");
    checkOutput("add_latency", 256'(doneSeenCycle - doneCycle), 256'(2));
    checkOutput("add_starts", 256'(startCount - opCount), 256'(1));
    checkOutput("add_stable", 256'(operandMoved), 256'(0));

    // SUB 2 - (p-1) = 3, operand B becomes p-(p-1) = 1
    applyStimulus("sub_neg", 2'd1, 3'd3, 3'd1, 3'd0, 1'b1, 256'd3);
    checkOutput("sub_neg_a", add_a, 256'd2);
    checkOutput("sub_neg_b", add_b, 256'd1);
    waitDone("sub_neg");

    // SUB by zero keeps operand B at zero
    hostWrite(3'd4, '0);
    applyStimulus("sub_zero", 2'd1, 3'd5, 3'd1, 3'd4, 1'b1, 256'd2);
    checkOutput("sub_zero_b", add_b, '0);
    waitDone("sub_zero");

    // In-place DBL of p-1 gives p-2; srcb is ignored
    applyStimulus("dbl_inplace", 2'd2, 3'd0, 3'd0, 3'd3, 1'b1, P - 256'd2);
    checkOutput("dbl_a", add_a, P - 256'd1);
    checkOutput("dbl_b", add_b, P - 256'd1);
    waitDone("dbl_inplace");

    // MOV bypasses the adder
    opCount = startCount;
    applyStimulus("mov", 2'd3, 3'd6, 3'd1, 3'd0, 1'b1, 256'd2);
    checkOutput("mov_busy", 256'(cmd_ready), 256'(0));
    checkOutput("mov_nostart", 256'(add_start), 256'(0));
    waitDone("mov");
    checkOutput("mov_latency", 256'(doneSeenCycle - acceptCycle), 256'(2));
    checkOutput("mov_starts", 256'(startCount - opCount), 256'(0));

    // Host write collides with writeback to R2: writeback wins (2+2=4)
    doneValid = 1'b0;
    applyStimulus("wb_wins", 2'd0, 3'd2, 3'd1, 3'd1, 1'b1, 256'd4);
    for (int i = 0; i < 50 && !(doneValid && cycleCnt == doneCycle + 1); i++) tick();
    checkOutput("wb_sync", 256'(doneValid), 256'(1));
    wr_en   = 1'b1;
    wr_addr = 3'd2;
    wr_data = 256'h55;
    tick();
    wr_en   = 1'b0;
    waitDone("wb_wins");

    // Host write to a source during WAIT does not disturb the snapshot:
    // (p-2) + 2 = 0 mod p
    modelDelay   = 4;
    operandMoved = 1'b0;
    applyStimulus("snap", 2'd0, 3'd7, 3'd0, 3'd1, 1'b1, '0);
    tick();
    hostWrite(3'd0, 256'd5);
    checkOutput("snap_a", add_a, P - 256'd2);
    waitDone("snap");
    checkOutput("snap_stable", 256'(operandMoved), 256'(0));
    readReg(3'd0);
    checkOutput("snap_r0", rd_data, 256'd5);
    modelDelay = 2;

    // Reset during WAIT abandons the command; a late add_done is ignored
    modelOn = 1'b0;
    applyStimulus("rst_wait", 2'd0, 3'd4, 3'd1, 3'd1, 1'b0, '0);
    repeat (2) tick();
    rst_n = 1'b0;
    tick();
    checkOutput("rstw_a", add_a, '0);
    checkOutput("rstw_b", add_b, '0);
    checkOutput("rstw_start", 256'(add_start), 256'(0));
    checkOutput("rstw_done", 256'(cmd_done), 256'(0));
    checkOutput("rstw_rd", rd_data, '0);
    checkOutput("rstw_ready", 256'(cmd_ready), 256'(1));
    rst_n       = 1'b1;
    injectValue = 256'h77;
    injectDone  = 1'b1;
    doneHits    = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (cmd_done === 1'b1) doneHits++;
    end
    checkOutput("rstw_nodone", 256'(doneHits), 256'(0));
    readReg(3'd4);
    checkOutput("rstw_r4", rd_data, '0);

    // Adder never answers
    hostWrite(3'd1, 256'd2);
    applyStimulus("stall", 2'd0, 3'd3, 3'd1, 3'd1, 1'b0, '0);
    doneHits = 0;
`ifdef SECP256K1_FE_ALU_TIMEOUT_EN
    for (int i = 0; i < 40 && err !== 1'b1; i++) begin
      tick();
      if (cmd_done === 1'b1) doneHits++;
    end
    checkOutput("tmo_err", 256'(err), 256'(1));
    checkOutput("tmo_ready", 256'(cmd_ready), 256'(1));
    checkOutput("tmo_nodone", 256'(doneHits), 256'(0));
    readReg(3'd3);
    checkOutput("tmo_r3", rd_data, '0);
`else
    for (int i = 0; i < 30; i++) begin
      tick();
      if (cmd_done === 1'b1) doneHits++;
    end
    checkOutput("stall_err", 256'(err), 256'(0));
    checkOutput("stall_busy", 256'(cmd_ready), 256'(0));
    checkOutput("stall_nodone", 256'(doneHits), 256'(0));
`endif
    rst_n = 1'b0;
    tick();
    rst_n   = 1'b1;
    modelOn = 1'b1;
    tick();

    checkOutput("sb_drained", 256'(sbQueue.size()), 256'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/secp256k1_fe_alu_ctrl.md
Name: secp256k1_fe_alu_ctrl

Overview:
- Field-element register file plus command sequencer that sits directly upstream and downstream of the secp256k1 modular adder.
- Accepts ADD/SUB/DBL/MOV commands on register indices and fetches operands.
- For ADD/SUB/DBL, drives the adder's start/a/b inputs, waits for its done pulse, and writes the result back into the register file.
- Forms the field-arithmetic core used by later point-add/point-double schedulers.

Parameters:
NREGS, 8, number of 256-bit field-element registers (power of two)
AW, 3, register index width, equal to log2(NREGS)
TIMEOUT_CYCLES, 16, adder watchdog limit (used only with the optional feature)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  high when state==IDLE (combinational)
cmd_op  input  2  0=ADD, 1=SUB, 2=DBL, 3=MOV
cmd_dst  input  AW  destination register
cmd_srca  input  AW  source A register
cmd_srcb  input  AW  source B register (ignored for DBL and MOV)
cmd_done  output  1  one-cycle pulse when the destination register is written
wr_en  input  1  host register load strobe
wr_addr  input  AW  host load address
wr_data  input  256  host load data; must be < p
rd_addr  input  AW  host readback address
rd_data  output  256  registered readback data, 1-cycle latency
add_start  output  1  one-cycle start pulse to the adder
add_a  output  256  adder operand A, held stable from ISSUE until add_done
add_b  output  256  adder operand B, held stable from ISSUE until add_done
add_result  input  256  adder result, sampled when add_done=1
add_done  input  1  adder completion pulse
err  output  1  sticky timeout flag (tied 0 when the optional feature is off)

Behaviour:
- Reset (async, rst_n low) clears the following, and holds them cleared while rst_n is low:
  - every register, rd_data, add_a, add_b, add_start, cmd_done and err go to 0;
  - the state machine goes to IDLE.
- Reset asserted mid-operation abandons the command with no writeback. A late add_done arriving after reset is ignored, because the block is in IDLE.
- Every computed command operates mod p, where p = 2^256 - 2^32 - 977.
- Operand snapshot: on the accept cycle (cmd_valid && cmd_ready), latch op and dst and snapshot R[srca] and R[srcb]. Later host writes do not affect the command in flight.
- Operand mapping:
  - ADD: opA = R[a], opB = R[b].
  - DBL: opA = opB = R[a].
  - SUB: opA = R[a]; opB = (R[b] == 0) ? 0 : p - R[b], computed in 256 bits, no borrow possible.
- State machine:
  - IDLE: cmd_ready=1. On accept, MOV goes to WB with result = R[a]; all other ops go to ISSUE.
  - ISSUE: add_start=1 for exactly one cycle; add_a/add_b are driven from opA/opB. Next state WAIT.
  - WAIT: add_start=0. When add_done=1, capture add_result and go to WB. add_done is ignored in every other state.
  - WB: write the result into R[dst] at the clock edge, pulse cmd_done for one cycle, return to IDLE.
- Latency:
  - MOV: cmd_done asserts 2 cycles after the accept cycle.
  - ADD/SUB/DBL: cmd_done asserts 2 cycles after the cycle add_done is seen high.
  - At most one command is in flight; cmd_ready stays low from ISSUE through WB.
- Host write port:
  - wr_en is honoured in any cycle.
  - If a host write and the WB writeback hit the same address in the same cycle, the writeback wins and the host write is dropped.
- Readback: rd_data reflects register contents as of the previous edge; no bypass of a same-cycle write.
- dst may equal srca or srcb; the snapshot makes in-place operation correct.

Optional Feature:
- Macro: SECP256K1_FE_ALU_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WAIT and increments each cycle in WAIT.
  - When it reaches TIMEOUT_CYCLES with no add_done, err is set (sticky until reset) and the state returns to IDLE with no writeback and no cmd_done.
- Undefined: there is no counter, err is constant 0, and WAIT lasts indefinitely.

Test Plan:
- Load R0=p-1, R1=2; ADD dst=2, a=0, b=1 -> R2=1, exactly one add_start pulse, one cmd_done pulse; add_a=p-1 and add_b=2 stable through add_done.
- With R0=p-1, R1=2: SUB dst=3, a=1, b=0 -> add_b=1, R3=3. Load R4=0; SUB dst=5, a=1, b=4 -> add_b=0, R5=2.
- DBL dst=0, a=0 with R0=p-1 -> R0=p-2, confirming in-place correctness.
- MOV dst=6, a=1 -> R6=2; add_start never asserts; cmd_done 2 cycles after accept. Back-to-back commands: cmd_ready low between accept and WB.
- Host write to R2 in the same cycle as the ADD writeback to R2 -> R2 holds the adder result. Host write to R0 during WAIT -> in-flight operand unchanged.
- Timeout build: adder model never asserts add_done -> err=1 after 16 WAIT cycles, dst unchanged, cmd_ready=1. Separately, rst_n low during WAIT -> all outputs 0, a following add_done causes no writeback.
